// File: rtl/ppu_pkg.sv
// Shared PPU constants: control-word layout and the bubble word.
// Used by control_unit, the datapath and the control pipeline.
package ppu_pkg;

   localparam int unsigned CW_DEFAULT = 14;

   localparam int unsigned AM_LSB      = 0;
   localparam int unsigned AM_W        = 2;
   localparam int unsigned RFEN_BIT    = 2;
   localparam int unsigned ALUOP_LSB   = 3;
   localparam int unsigned ALUOP_W     = 4;
   localparam int unsigned LOAD_BIT    = 7;
   localparam int unsigned BL_BIT      = 8;
   localparam int unsigned SBIT_BIT    = 9;
   localparam int unsigned RW_BIT      = 10;
   localparam int unsigned SIZE_BIT    = 11;
   localparam int unsigned DMEMEN_BIT  = 12;
   localparam int unsigned SPARE_BIT   = 13;

   // Field view of a default-width control word, MSB first.
   typedef struct packed {
      logic       spare;
      logic       datamem_en;
      logic       size;
      logic       rw;
      logic       s_bit;
      logic       branch_link;
      logic       load;
      logic [3:0] alu_op;
      logic       rf_en;
      logic [1:0] am;
   } ctrl_word_t;

   localparam logic [CW_DEFAULT-1:0] NOP_WORD = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One control-pipeline stage: a {valid, word} register with hold and bubble.
// An invalid stage always stores NOP_WORD so bubbles never drive enables.
module ctrl_stage_reg #(
   parameter int unsigned     CW       = ppu_pkg::CW_DEFAULT,
   parameter logic [CW-1:0]   NOP_WORD = CW'(ppu_pkg::NOP_WORD)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic          bubble,
   input  logic [CW:0]   load_word,
   output logic [CW-1:0] word_o,
   output logic          valid_o
);

   logic [CW:0] stage_q;
   logic [CW:0] stage_d;

   always_comb begin
      stage_d = stage_q;
      if (!hold) begin
         if (bubble || !load_word[CW]) begin
            stage_d = {1'b0, NOP_WORD};
         end else begin
            stage_d = load_word;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= {1'b0, NOP_WORD};
      end else begin
         stage_q <= stage_d;
      end
   end

   assign word_o  = stage_q[CW-1:0];
   assign valid_o = stage_q[CW];

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from ID/EX to MEM/WB with flush, stall, hold,
// per-stage valid bits and saturating bubble/retire counters.
module ctrl_pipe_chain #(
   parameter int unsigned   CW       = ppu_pkg::CW_DEFAULT,
   parameter int unsigned   NSTG     = 3,
   parameter int unsigned   CNTW     = 16,
   parameter logic [CW-1:0] NOP_WORD = CW'(ppu_pkg::NOP_WORD)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CW-1:0]      in_ctrl,
   input  logic               in_valid,
   input  logic               stall,
   input  logic               hold,
   input  logic [NSTG-1:0]    flush,
   output logic               in_ready,
   output logic [NSTG*CW-1:0] stg_ctrl,
   output logic [NSTG-1:0]    stg_valid,
   output logic [CNTW-1:0]    bubble_cnt,
   output logic [CNTW-1:0]    retire_cnt
);

   logic [CW-1:0]   stg_word [NSTG];
   logic [NSTG-1:0] valid_w;

   logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;
   logic [CNTW-1:0] retire_cnt_q, retire_cnt_d;

   assign in_ready = !(stall || hold || flush[0]);

   for (genvar i = 0; i < NSTG; i++) begin : g_stage
      logic [CW:0] load_word;
      logic        bubble;

      // Stage 0 is fed by decode; later stages by their upstream neighbour.
      if (i == 0) begin : g_head
         assign load_word = {in_valid, in_ctrl};
         assign bubble    = stall || flush[0];
      end else begin : g_body
         assign load_word = {valid_w[i-1], stg_word[i-1]};
         assign bubble    = flush[i];
      end

      ctrl_stage_reg #(
         .CW       (CW),
         .NOP_WORD (NOP_WORD)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .hold      (hold),
         .bubble    (bubble),
         .load_word (load_word),
         .word_o    (stg_word[i]),
         .valid_o   (valid_w[i])
      );

      assign stg_ctrl[i*CW +: CW] = stg_word[i];
   end

   assign stg_valid = valid_w;

   // Stall and flush[0] together still insert only one bubble.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (!hold) begin
         if ((stall || flush[0]) && (bubble_cnt_q != {CNTW{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNTW'(1);
         end
         if (valid_w[NSTG-1] && (retire_cnt_q != {CNTW{1'b1}})) begin
            retire_cnt_d = retire_cnt_q + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt_q <= '0;
         retire_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain; a second instance with 4-bit
// counters shares the stimulus and is used for saturation.
module tb_ctrl_pipe_chain;

   localparam int unsigned CW   = 14;
   localparam int unsigned NSTG = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [CW-1:0]      in_ctrl;
   logic               in_valid;
   logic               stall;
   logic               hold;
   logic [NSTG-1:0]    flush;
   logic               in_ready, s_in_ready;
   logic [NSTG*CW-1:0] stg_ctrl, s_stg_ctrl;
   logic [NSTG-1:0]    stg_valid, s_stg_valid;
   logic [15:0]        bubble_cnt, retire_cnt;
   logic [3:0]         s_bubble_cnt, s_retire_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ctrl_pipe_chain #(.CW(CW), .NSTG(NSTG), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .in_ctrl(in_ctrl), .in_valid(in_valid),
      .stall(stall), .hold(hold), .flush(flush), .in_ready(in_ready),
      .stg_ctrl(stg_ctrl), .stg_valid(stg_valid),
      .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
   );

   ctrl_pipe_chain #(.CW(CW), .NSTG(NSTG), .CNTW(4)) dut_sat (
      .clk(clk), .reset(reset), .in_ctrl(in_ctrl), .in_valid(in_valid),
      .stall(stall), .hold(hold), .flush(flush), .in_ready(s_in_ready),
      .stg_ctrl(s_stg_ctrl), .stg_valid(s_stg_valid),
      .bubble_cnt(s_bubble_cnt), .retire_cnt(s_retire_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_ctrl  = '0;
      in_valid = 1'b0;
      stall    = 1'b0;
      hold     = 1'b0;
      flush    = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (stg_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid: got %b want %b", stg_valid, 3'b000); end
      n_cmp++; if (stg_ctrl !== 42'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want %h", stg_ctrl, 42'h0); end
      n_cmp++; if (bubble_cnt !== 16'd0 || retire_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bubble_cnt, retire_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      n_cmp++; if (s_bubble_cnt !== 4'd0 || s_stg_valid !== 3'b000) begin n_err++; $display("FAIL reset_sat: got %0d/%b want 0/000", s_bubble_cnt, s_stg_valid); end
   endtask

   task automatic test_streaming();
      in_valid = 1'b1;
      in_ctrl  = 14'h0001; tick();
      in_ctrl  = 14'h0002; tick();
      in_ctrl  = 14'h0003; tick();
      n_cmp++; if (stg_ctrl[2*CW +: CW] !== 14'h0001) begin n_err++; $display("FAIL stream_stage2_first: got %h want %h", stg_ctrl[2*CW +: CW], 14'h0001); end
      n_cmp++; if (stg_ctrl !== {14'h0001, 14'h0002, 14'h0003}) begin n_err++; $display("FAIL stream_full: got %h want %h", stg_ctrl, {14'h0001, 14'h0002, 14'h0003}); end
      n_cmp++; if (stg_valid !== 3'b111 || retire_cnt !== 16'd0) begin n_err++; $display("FAIL stream_valid: got %b/%0d want 111/0", stg_valid, retire_cnt); end
      in_valid = 1'b0;
      in_ctrl  = 14'h3FFF;
      tick();
      n_cmp++; if (stg_ctrl !== {14'h0002, 14'h0003, 14'h0000} || stg_valid !== 3'b110) begin n_err++; $display("FAIL stream_invalid_nop: got %h/%b want %h/110", stg_ctrl, stg_valid, {14'h0002, 14'h0003, 14'h0000}); end
      tick();
      tick();
      n_cmp++; if (retire_cnt !== 16'd3) begin n_err++; $display("FAIL stream_retire: got %0d want 3", retire_cnt); end
      n_cmp++; if (stg_valid !== 3'b000 || stg_ctrl !== 42'h0 || bubble_cnt !== 16'd0) begin n_err++; $display("FAIL stream_drain: got %b/%h/%0d want 000/0/0", stg_valid, stg_ctrl, bubble_cnt); end
      tick();
      n_cmp++; if (retire_cnt !== 16'd3) begin n_err++; $display("FAIL stream_retire_idle: got %0d want 3", retire_cnt); end
   endtask

   task automatic test_stall();
      in_ctrl  = 14'h1234;
      in_valid = 1'b1;
      stall    = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
      tick();
      n_cmp++; if (stg_valid[0] !== 1'b0 || stg_ctrl[CW-1:0] !== 14'h0000) begin n_err++; $display("FAIL stall_bubble: got %b/%h want 0/0000", stg_valid[0], stg_ctrl[CW-1:0]); end
      n_cmp++; if (bubble_cnt !== 16'd1) begin n_err++; $display("FAIL stall_bubble_cnt: got %0d want 1", bubble_cnt); end
      stall = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      tick();
      n_cmp++; if (stg_ctrl !== {14'h0, 14'h0, 14'h1234} || stg_valid !== 3'b001) begin n_err++; $display("FAIL stall_accept: got %h/%b want %h/001", stg_ctrl, stg_valid, {14'h0, 14'h0, 14'h1234}); end
   endtask

   task automatic test_flush();
      in_ctrl = 14'h0AAA; tick();
      in_ctrl = 14'h0BBB; tick();
      n_cmp++; if (stg_ctrl !== {14'h1234, 14'h0AAA, 14'h0BBB} || retire_cnt !== 16'd3) begin n_err++; $display("FAIL flush_fill: got %h/%0d want %h/3", stg_ctrl, retire_cnt, {14'h1234, 14'h0AAA, 14'h0BBB}); end
      in_ctrl = 14'h0CCC;
      flush   = 3'b011;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
      tick();
      n_cmp++; if (stg_ctrl !== {14'h0AAA, 14'h0, 14'h0} || stg_valid !== 3'b100) begin n_err++; $display("FAIL flush_stages: got %h/%b want %h/100", stg_ctrl, stg_valid, {14'h0AAA, 14'h0, 14'h0}); end
      n_cmp++; if (bubble_cnt !== 16'd2 || retire_cnt !== 16'd4) begin n_err++; $display("FAIL flush_cnt: got %0d/%0d want 2/4", bubble_cnt, retire_cnt); end
      flush = 3'b000;
   endtask

   task automatic test_hold_vs_flush();
      in_ctrl = 14'h0111; tick();
      in_ctrl = 14'h0222; tick();
      in_ctrl = 14'h0333; tick();
      hold    = 1'b1;
      flush   = 3'b111;
      in_ctrl = 14'h0444;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_cmp++; if (stg_ctrl !== {14'h0111, 14'h0222, 14'h0333} || stg_valid !== 3'b111) begin n_err++; $display("FAIL hold_frozen%0d: got %h/%b want %h/111", c, stg_ctrl, stg_valid, {14'h0111, 14'h0222, 14'h0333}); end
         n_cmp++; if (bubble_cnt !== 16'd2 || retire_cnt !== 16'd5) begin n_err++; $display("FAIL hold_cnt%0d: got %0d/%0d want 2/5", c, bubble_cnt, retire_cnt); end
      end
      hold = 1'b0;
      tick();
      n_cmp++; if (stg_ctrl !== 42'h0 || stg_valid !== 3'b000) begin n_err++; $display("FAIL hold_then_flush: got %h/%b want 0/000", stg_ctrl, stg_valid); end
      n_cmp++; if (bubble_cnt !== 16'd3 || retire_cnt !== 16'd6) begin n_err++; $display("FAIL hold_then_flush_cnt: got %0d/%0d want 3/6", bubble_cnt, retire_cnt); end
      flush = 3'b000;
   endtask

   task automatic test_stall_and_flush();
      in_ctrl = 14'h0999;
      stall   = 1'b1;
      flush   = 3'b001;
      tick();
      n_cmp++; if (bubble_cnt !== 16'd4 || stg_valid !== 3'b000) begin n_err++; $display("FAIL stall_flush_one_bubble: got %0d/%b want 4/000", bubble_cnt, stg_valid); end
      stall = 1'b0;
      flush = 3'b000;
   endtask

   task automatic test_reset_mid();
      in_ctrl = 14'h0555; tick();
      in_ctrl = 14'h0666; tick();
      in_ctrl = 14'h0777; tick();
      n_cmp++; if (stg_valid !== 3'b111) begin n_err++; $display("FAIL rstmid_fill: got %b want 111", stg_valid); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (stg_valid !== 3'b000 || stg_ctrl !== 42'h0) begin n_err++; $display("FAIL rstmid_stages: got %b/%h want 000/0", stg_valid, stg_ctrl); end
      n_cmp++; if (bubble_cnt !== 16'd0 || retire_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", bubble_cnt, retire_cnt); end
      tick();
      reset = 1'b0;
      idle_inputs();
      tick();
      n_cmp++; if (stg_valid !== 3'b000 || retire_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_after: got %b/%0d want 000/0", stg_valid, retire_cnt); end
   endtask

   task automatic test_saturation();
      stall = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      stall = 1'b0;
      n_cmp++; if (s_bubble_cnt !== 4'd15) begin n_err++; $display("FAIL sat_bubble: got %0d want 15", s_bubble_cnt); end
      n_cmp++; if (bubble_cnt !== 16'd20) begin n_err++; $display("FAIL sat_wide_bubble: got %0d want 20", bubble_cnt); end
      tick();
      n_cmp++; if (s_bubble_cnt !== 4'd15 || s_retire_cnt !== 4'd0) begin n_err++; $display("FAIL sat_stays: got %0d/%0d want 15/0", s_bubble_cnt, s_retire_cnt); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_stall();
      test_flush();
      test_hold_vs_flush();
      test_stall_and_flush();
      test_reset_mid();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised control-word pipeline for the ARM-subset PPU. It replaces the fixed chain of cuMux, id_exe_reg, exe_mem_reg and mem_wb_reg. Decoded control words from control_unit enter at stage 0 (ID/EX) and advance one stage per cycle to stage NSTG-1 (MEM/WB). The chain adds per-stage flush, load-use stall with bubble insertion, global hold, per-stage valid bits and saturating bubble/retire counters.

## Interface
Parameters:
- CW, 14, control-word width (AM[1:0], rf_en, alu_op[3:0], load, branch_link, s_bit, rw, size, datamem_en, 1 spare)
- NSTG, 3, number of pipeline stages after decode (≥2)
- CNTW, 16, counter width
- NOP_WORD, all zeros, control word loaded for a bubble

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_ctrl  in  CW  control word from control_unit
- in_valid  in  1  in_ctrl carries a real instruction
- stall  in  1  load-use stall: stage 0 takes a bubble and the decode side must hold
- hold  in  1  freeze the whole chain (memory wait)
- flush  in  NSTG  per-stage flush mask; bit i squashes stage i
- in_ready  out  1  chain accepts in_ctrl this cycle; equals !(stall | hold | flush[0])
- stg_ctrl  out  NSTG*CW  flattened stage words; stage i occupies bits [i*CW +: CW]
- stg_valid  out  NSTG  per-stage valid
- bubble_cnt  out  CNTW  bubbles inserted by stall or flush[0]
- retire_cnt  out  CNTW  valid words leaving stage NSTG-1

## Operation
- **Reset.** All stg_ctrl = NOP_WORD, stg_valid = 0, both counters = 0, in_ready = 1 once reset is low. Reset asserted mid-operation discards all stages in the same cycle.
- **Per-edge priority:** reset > hold > flush > stall > normal.
- **hold = 1.** Every stage keeps its word and valid bit. Counters do not change. flush and stall are ignored that cycle; the requester keeps asserting them until hold drops.
- **flush[i] = 1** (hold = 0). Stage i loads NOP_WORD with valid 0 instead of its upstream word. Other stages advance normally. Flushing stage i does not block stage i+1 from taking stage i's old word. A full-chain squash means asserting all bits.
- **stall = 1** (hold = 0, flush[0] = 0). Stage 0 loads NOP_WORD with valid 0. Stages 1..NSTG-1 advance. in_ctrl is not consumed.
- **Normal.** Stage 0 loads in_ctrl with valid in_valid. If in_valid = 0, stage 0 loads NOP_WORD. Stage i loads stage i-1.
- **Invalid stages.** An invalid stage always presents NOP_WORD on stg_ctrl, so downstream enables (rf_en, datamem_en) are never asserted by a bubble.
- **bubble_cnt** increments by 1 on any non-hold edge where stall = 1 or flush[0] = 1. It does not increment for in_valid = 0. It saturates at 2^CNTW-1.
- **retire_cnt** increments by 1 on any non-hold edge where stg_valid[NSTG-1] = 1. It saturates at 2^CNTW-1.

## Timing
- Latency: a word accepted on edge n appears on stage k after edge n+k, which is k+1 cycles from presentation.
- Throughput: one word per cycle while in_ready = 1.
- in_ready and all outputs are registered or derived combinationally only from inputs; there are no combinational loops through stg_*.
- Simultaneous stall and flush[0] count as one bubble.

## Structure
- Shared package ppu_pkg holds:
  - control-word field offsets and widths (AM_LSB, RFEN_BIT, ALUOP_LSB, …);
  - CW_DEFAULT = 14;
  - NOP_WORD.
- control_unit and the datapath use the same constants.
- One sub-module, ctrl_stage_reg: a CW+1-bit register with async reset and inputs load_word, bubble and hold. It is generated NSTG times.
- Counters live in the top level.

## Test plan
- **Streaming.** Reset, then feed words 0x0001, 0x0002, 0x0003 with in_valid = 1 on consecutive edges. Required: stage 2 shows 0x0001 three cycles after the first presentation; retire_cnt = 3 after the third word leaves stage 2.
- **Load-use stall.** Assert stall for one cycle while in_ctrl = 0x1234. Required: stage 0 = NOP_WORD with valid 0; in_ready = 0 during that cycle; 0x1234 accepted the next cycle; bubble_cnt = 1.
- **Flush.** Assert flush = 3'b011 with the chain full of valid words. Required: stages 0 and 1 are invalid/NOP after the edge; stage 2 holds the old stage-1 word; bubble_cnt increments by 1.
- **Hold versus flush.** Assert hold = 1 and flush = 3'b111 for 2 cycles. Required: all stages and counters unchanged; after hold drops with flush still asserted, all stages are invalid.
- **Saturation.** With CNTW = 4, assert stall for 20 cycles. Required: bubble_cnt stops at 15.
- **Reset mid-stream.** Pulse reset between clock edges while the chain is full. Required: stg_valid = 0, stg_ctrl = NOP_WORD and counters = 0 before the next edge.
